// File: rtl/rca_seq_ctrl.sv
// rca_seq_ctrl: wide add/subtract built from one 4-bit ripple-carry adder.
// Each operation takes NIBBLES cycles, one nibble per cycle, least-significant
// nibble first. The inter-nibble carry is held in a register.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready   operand handshake (op_a, op_b, cin, sub)
//   out_valid/out_ready result handshake (result, cout)
//   overflow            two's-complement overflow, only when OVF_DETECT_EN
//                       is defined; valid with out_valid
//
// Build option: define OVF_DETECT_EN to add the overflow output.
module rca_seq_ctrl #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NIBBLES-1:0]   op_a,
  input  logic [4*NIBBLES-1:0]   op_b,
  input  logic                   cin,
  input  logic                   sub,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NIBBLES-1:0]   result,
  output logic                   cout
`ifdef OVF_DETECT_EN
  ,
  output logic                   overflow
`endif
);

  localparam int unsigned W    = 4 * NIBBLES;
  localparam int unsigned IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [W-1:0]    a_reg;
  logic [W-1:0]    b_reg;      // operand B, already inverted for subtract
  logic            carry_reg;
  logic [IDXW-1:0] idx;

  logic [3:0]      a_nib;
  logic [3:0]      b_nib;
  logic [3:0]      sum_nib;
  logic [4:0]      rc;         // ripple carries; rc[3] is the carry into bit 3
  logic [W-1:0]    result_nxt;
  logic            last_nib;

  assign last_nib = (idx == IDXW'(NIBBLES - 1));

  // Nibble select, 4-bit ripple-carry adder and result nibble merge
  always_comb begin
    a_nib      = '0;
    b_nib      = '0;
    sum_nib    = '0;
    rc         = '0;
    result_nxt = result;
    for (int k = 0; k < int'(NIBBLES); k++) begin
      if (idx == IDXW'(k)) begin
        a_nib = a_reg[4*k +: 4];
        b_nib = b_reg[4*k +: 4];
      end
    end
    rc[0] = carry_reg;
    for (int i = 0; i < 4; i++) begin
      sum_nib[i] = a_nib[i] ^ b_nib[i] ^ rc[i];
      rc[i+1]    = (a_nib[i] & b_nib[i]) | (rc[i] & (a_nib[i] ^ b_nib[i]));
    end
    for (int k = 0; k < int'(NIBBLES); k++) begin
      if (idx == IDXW'(k)) begin
        result_nxt[4*k +: 4] = sum_nib;
      end
    end
  end

  // Sequencer: accept, iterate nibbles, hold result until consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      idx       <= '0;
      result    <= '0;
      cout      <= 1'b0;
`ifdef OVF_DETECT_EN
      overflow  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          if (in_valid && in_ready) begin
            a_reg     <= op_a;
            b_reg     <= sub ? ~op_b : op_b;
            carry_reg <= sub | cin;
            idx       <= '0;
            in_ready  <= 1'b0;
            state     <= RUN;
          end
        end
        RUN: begin
          result    <= result_nxt;
          carry_reg <= rc[4];
          if (last_nib) begin
            cout      <= rc[4];
`ifdef OVF_DETECT_EN
            overflow  <= rc[3] ^ rc[4];
`endif
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + IDXW'(1);
          end
        end
        DONE: begin
          // in_ready only rises after this handshake, so no same-cycle re-accept
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Directed bench for rca_seq_ctrl (NIBBLES=4). Overflow checks are included
// when OVF_DETECT_EN is defined.
module tb_rca_seq_ctrl;

  localparam int unsigned N = 4;
  localparam int unsigned W = 4 * N;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         cout;
`ifdef OVF_DETECT_EN
  logic         overflow;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  rca_seq_ctrl #(.NIBBLES(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout)
`ifdef OVF_DETECT_EN
    ,
    .overflow  (overflow)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One full operation with out_ready high when the result appears
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic ci, input logic s, input logic [15:0] er,
                        input logic ec, input logic eo);
    int t;
    int lat;
    @(negedge clk);
    in_valid = 1'b1; op_a = a; op_b = b; cin = ci; sub = s;
    t = 0;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    op_a = 16'($urandom);
    op_b = 16'($urandom);
    cin  = ~ci;
    sub  = ~s;
    lat  = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(N));
    chk({tag, "_result"}, 32'(result), 32'(er));
    chk({tag, "_cout"}, 32'(cout), 32'(ec));
    chk({tag, "_busy"}, 32'(in_ready), 32'd0);
`ifdef OVF_DETECT_EN
    chk({tag, "_ovf"}, 32'(overflow), 32'(eo));
`else
    if (eo === 1'bx) $display("unexpected overflow expectation");
`endif
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_post_ovalid"}, 32'(out_valid), 32'd0);
    chk({tag, "_post_iready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int t;
    clk = 1'b0; rst_n = 1'b0; in_valid = 1'b0; op_a = '0; op_b = '0;
    cin = 1'b0; sub = 1'b0; out_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", 32'(in_ready), 32'd1);

    // Basic arithmetic
    run_op("add_5555", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
    run_op("ripple_p1", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("ripple_cin", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("sub_borrow", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_op("sub_pos", 16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0);
    run_op("add_mixed", 16'hABCD, 16'h1234, 1'b1, 1'b0, 16'hBE02, 1'b0, 1'b0);
    run_op("ovf_add", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("ovf_sub", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);

    // Backpressure in DONE with noisy inputs
    @(negedge clk);
    in_valid = 1'b1; op_a = 16'h1111; op_b = 16'h2222; cin = 1'b0; sub = 1'b0;
    t = 0;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("bp_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    t = 0;
    while (!out_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("bp_latency", 32'(t), 32'(N));
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_result", 32'(result), 32'h3333);
      chk("bp_hold_cout", 32'(cout), 32'd0);
      chk("bp_hold_ovalid", 32'(out_valid), 32'd1);
      chk("bp_hold_iready", 32'(in_ready), 32'd0);
`ifdef OVF_DETECT_EN
      chk("bp_hold_ovf", 32'(overflow), 32'd0);
`endif
      in_valid = ~in_valid;
      op_a = 16'($urandom);
      op_b = 16'($urandom);
      cin  = ~cin;
      sub  = ~sub;
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_release_ovalid", 32'(out_valid), 32'd0);
    chk("bp_release_iready", 32'(in_ready), 32'd1);
    run_op("bp_next", 16'h0100, 16'h0023, 1'b0, 1'b0, 16'h0123, 1'b0, 1'b0);

    // Put cout=1 on the output so the reset clear below is observable
    run_op("pre_rst", 16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0);

    // Reset during the second RUN cycle
    @(negedge clk);
    in_valid = 1'b1; op_a = 16'h1234; op_b = 16'h4321; cin = 1'b0; sub = 1'b0;
    t = 0;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("mid_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_result", 32'(result), 32'd0);
    chk("mid_rst_cout", 32'(cout), 32'd0);
    chk("mid_rst_ovalid", 32'(out_valid), 32'd0);
    chk("mid_rst_iready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_after_iready", 32'(in_ready), 32'd1);
    t = 0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid) t++;
      @(negedge clk);
    end
    chk("mid_no_ovalid", 32'(t), 32'd0);
    run_op("fresh", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
